c4_move_entry: RTL and testbench

Player move-entry stage that sits directly upstream of the Connect4 game core and drives its `G`/`O` column inputs. It synchronises and debounces a shared 4-button column keypad and alternates turns between Green and Orange. It tracks column heights so that moves into full columns are rejected, and presents each accepted move as a one-hot column on `G` or `O` for a fixed hold time. It stops accepting moves once the core reports a result or the board is full.

---
 rtl/c4_pkg.sv | 26 ++
 rtl/c4_btn_sync.sv | 29 ++
 rtl/c4_move_entry.sv | 187 ++++++++++++++++++
 tb/tb_c4_move_entry.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared Connect4 definitions: board geometry, game-core result codes and
// the move-entry state encoding.
package c4_pkg;

   localparam int COLS = 4;
   localparam int ROWS = 6;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_G    = 2'b01;
   localparam logic [1:0] RES_O    = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_PRESS,
      ST_DEBOUNCE,
      ST_DRIVE,
      ST_WAIT_RELEASE,
      ST_LOCK
   } entry_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/c4_btn_sync.sv
// Two-flop synchroniser for the shared column keypad plus a one-hot detector
// on the synchronised value.
module c4_btn_sync #(
   parameter int COLS = c4_pkg::COLS
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [COLS-1:0] BTN,
   output logic [COLS-1:0] bs,
   output logic            onehot
);
   import c4_pkg::*;

   logic [COLS-1:0] meta;

   always_ff @(posedge CLK) begin
      if (RST) begin
         meta <= '0;
         bs   <= '0;
      end else begin
         meta <= BTN;
         bs   <= meta;
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign onehot = (bs != '0) && ((bs & (bs - 1'b1)) == '0);

endmodule

// File: rtl/c4_move_entry.sv
// Move-entry stage feeding the Connect4 core: debounced keypad, turn
// alternation, column-height tracking and game-over lockout.
//
// state           | meaning
// ----------------+-----------------------------------------------------
// ST_IDLE         | board cleared, Green to move, waiting for start
// ST_WAIT_PRESS   | waiting for a single (one-hot) column key
// ST_DEBOUNCE     | latched key must stay stable for DEB_CYC cycles
// ST_DRIVE        | accepted move presented on G or O for HOLD_CYC cycles
// ST_WAIT_RELEASE | keypad must read zero for DEB_CYC cycles
// ST_LOCK         | game over, outputs quiet until reset
module c4_move_entry #(
   parameter int COLS     = c4_pkg::COLS,
   parameter int ROWS     = c4_pkg::ROWS,
   parameter int DEB_CYC  = 16,
   parameter int HOLD_CYC = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [COLS-1:0] BTN,
   input  logic [1:0]      RESULT,
   output logic [COLS-1:0] G,
   output logic [COLS-1:0] O,
   output logic            TURN,
   output logic            REJECT,
   output logic            LOCKED
);
   import c4_pkg::*;

   localparam int HW = $clog2(ROWS + 1);
   localparam int MW = $clog2(ROWS * COLS + 1);
   localparam int CW = $clog2(max_int(DEB_CYC, HOLD_CYC) + 1);

   localparam logic [HW-1:0] H_FULL     = HW'(ROWS);
   localparam logic [MW-1:0] M_FULL     = MW'(ROWS * COLS);
   localparam logic [CW-1:0] DEB_TC     = CW'(DEB_CYC);
   localparam logic [CW-1:0] DEB_TC_M1  = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] HOLD_TC    = CW'(HOLD_CYC);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   entry_state_t    state, state_nxt;
   logic [COLS-1:0] bs;
   logic            bs_onehot;
   logic [COLS-1:0] col_q, col_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt, cnt_inc;
   logic [HW-1:0]   height_q [COLS];
   logic [HW-1:0]   col_height;
   logic [MW-1:0]   moves_q;
   logic            lock_cond;
   logic            accept, clear_board;
   logic            turn_nxt, reject_nxt, locked_nxt;
   logic [COLS-1:0] g_nxt, o_nxt;

   c4_btn_sync #(.COLS(COLS)) u_sync (
      .CLK    (CLK),
      .RST    (RST),
      .BTN    (BTN),
      .bs     (bs),
      .onehot (bs_onehot)
   );

   assign lock_cond = (RESULT != RES_NONE) || (moves_q == M_FULL);
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      col_height = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col_q[c]) col_height = height_q[c];
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt_q;
      col_nxt     = col_q;
      turn_nxt    = TURN;
      accept      = 1'b0;
      clear_board = 1'b0;
      reject_nxt  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            clear_board = 1'b1;
            turn_nxt    = 1'b0;
            cnt_nxt     = '0;
            if (start) state_nxt = ST_WAIT_PRESS;
         end
         ST_WAIT_PRESS: begin
            if (lock_cond) begin
               state_nxt = ST_LOCK;
            end else if (bs_onehot) begin
               col_nxt   = bs;
               cnt_nxt   = CNT_ONE;
               state_nxt = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (lock_cond) begin
               state_nxt = ST_LOCK;
            end else if (bs != col_q) begin
               state_nxt = ST_WAIT_PRESS;
            end else if (cnt_q >= DEB_TC) begin
               if (col_height == H_FULL) begin
                  reject_nxt = 1'b1;
                  cnt_nxt    = '0;
                  state_nxt  = ST_WAIT_RELEASE;
               end else begin
                  accept    = 1'b1;
                  cnt_nxt   = CNT_ONE;
                  state_nxt = ST_DRIVE;
               end
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ST_DRIVE: begin
            // The hold always runs to completion; a pending lock is honoured at its end.
            if (cnt_q >= HOLD_TC) begin
               turn_nxt  = ~TURN;
               cnt_nxt   = '0;
               state_nxt = lock_cond ? ST_LOCK : ST_WAIT_RELEASE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ST_WAIT_RELEASE: begin
            if (lock_cond) begin
               state_nxt = ST_LOCK;
            end else if (bs != '0) begin
               cnt_nxt = '0;
            end else if (cnt_q >= DEB_TC_M1) begin
               cnt_nxt   = '0;
               state_nxt = ST_WAIT_PRESS;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ST_LOCK: begin
            state_nxt = ST_LOCK;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      g_nxt      = '0;
      o_nxt      = '0;
      locked_nxt = (state_nxt == ST_LOCK);
      if (state_nxt == ST_DRIVE) begin
         if (turn_nxt) o_nxt = col_nxt;
         else          g_nxt = col_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         cnt_q   <= '0;
         col_q   <= '0;
         moves_q <= '0;
         for (int c = 0; c < COLS; c++) height_q[c] <= '0;
         G       <= '0;
         O       <= '0;
         TURN    <= 1'b0;
         REJECT  <= 1'b0;
         LOCKED  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt_q  <= cnt_nxt;
         col_q  <= col_nxt;
         G      <= g_nxt;
         O      <= o_nxt;
         TURN   <= turn_nxt;
         REJECT <= reject_nxt;
         LOCKED <= locked_nxt;
         if (clear_board)  moves_q <= '0;
         else if (accept)  moves_q <= moves_q + 1'b1;
         for (int c = 0; c < COLS; c++) begin
            if (clear_board)            height_q[c] <= '0;
            else if (accept && col_q[c]) height_q[c] <= height_q[c] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_c4_move_entry.sv
// Bench for c4_move_entry: vector table, directed corner sequences and a
// randomized run checked against a move-level game model.
module tb_c4_move_entry;
   localparam int COLS = 4;
   localparam int ROWS = 6;
   localparam int DEB  = 4;
   localparam int HOLD = 2;
   localparam int LAT  = DEB + 2;

   logic       CLK = 1'b0;
   logic       RST, start;
   logic [3:0] BTN;
   logic [1:0] RESULT;
   logic [3:0] G, O;
   logic       TURN, REJECT, LOCKED;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   c4_move_entry #(.COLS(COLS), .ROWS(ROWS), .DEB_CYC(DEB), .HOLD_CYC(HOLD)) dut (
      .CLK(CLK), .RST(RST), .start(start), .BTN(BTN), .RESULT(RESULT),
      .G(G), .O(O), .TURN(TURN), .REJECT(REJECT), .LOCKED(LOCKED)
   );

   typedef struct {
      logic [3:0] g_acc;
      logic [3:0] o_acc;
      int         g_cyc;
      int         o_cyc;
      int         rej;
      int         first;
      bit         bad;
   } obs_t;

   typedef struct {
      logic [3:0] btn;
      int         hold;
      logic [3:0] exp_g;
      logic [3:0] exp_o;
      int         exp_rej;
      logic       exp_turn;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Holds btn for `hold` sampled edges, then zero for `rel` edges, recording outputs.
   task automatic do_press(input logic [3:0] btn, input int hold, input int rel, output obs_t ob);
      ob.g_acc = '0; ob.o_acc = '0; ob.g_cyc = 0; ob.o_cyc = 0;
      ob.rej = 0; ob.first = -1; ob.bad = 1'b0;
      BTN = btn;
      for (int i = 0; i < hold + rel; i++) begin
         @(posedge CLK);
         #1;
         if (i == hold - 1) BTN = '0;
         if (G != '0) begin ob.g_acc |= G; ob.g_cyc++; end
         if (O != '0) begin ob.o_acc |= O; ob.o_cyc++; end
         if (REJECT) ob.rej++;
         if (ob.first < 0 && ((G | O) != '0 || REJECT)) ob.first = i;
         if ((G & O) != '0 || !$onehot0(G) || !$onehot0(O)) ob.bad = 1'b1;
      end
   endtask

   task automatic expect_ev(input string nm, input obs_t ob, input logic [3:0] eg,
                            input logic [3:0] eo, input int er);
      int ecyc;
      ecyc = (eg != '0 || eo != '0) ? HOLD : 0;
      check({nm, "_g"}, ob.g_acc, eg);
      check({nm, "_o"}, ob.o_acc, eo);
      check({nm, "_hold"}, ob.g_cyc + ob.o_cyc, ecyc);
      check({nm, "_rej"}, ob.rej, er);
      check({nm, "_onehot"}, ob.bad, 0);
      if (eg != '0 || eo != '0 || er != 0) check({nm, "_lat"}, ob.first, LAT);
   endtask

   task automatic do_reset_start();
      RST = 1'b1; start = 1'b0; BTN = '0; RESULT = 2'b00;
      tick(2);
      RST = 1'b0;
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vecs[5];
      obs_t  ob;
      logic  exp_turn;
      int    hc;
      bit    found;
      int    ht[COLS];
      int    moves;
      bit    m_locked;
      logic [3:0] p;

      vecs[0] = '{4'b0010, 10, 4'b0010, 4'b0000, 0, 1'b1};
      vecs[1] = '{4'b0011, 20, 4'b0000, 4'b0000, 0, 1'b1};
      vecs[2] = '{4'b0001,  8, 4'b0000, 4'b0001, 0, 1'b0};
      vecs[3] = '{4'b1000,  7, 4'b1000, 4'b0000, 0, 1'b1};
      vecs[4] = '{4'b0110, 12, 4'b0000, 4'b0000, 0, 1'b1};

      // Reset values
      RST = 1'b1; start = 1'b0; BTN = '0; RESULT = 2'b00;
      tick(2);
      check("rst_g", G, 0);
      check("rst_o", O, 0);
      check("rst_turn", TURN, 0);
      check("rst_reject", REJECT, 0);
      check("rst_locked", LOCKED, 0);
      RST = 1'b0;
      tick(1);

      do_press(4'b0010, 10, 10, ob);
      expect_ev("idle_ignore", ob, 4'b0000, 4'b0000, 0);

      start = 1'b1; tick(1); start = 1'b0; tick(1);

      for (int v = 0; v < 5; v++) begin
         do_press(vecs[v].btn, vecs[v].hold, 12, ob);
         expect_ev($sformatf("vec%0d", v), ob, vecs[v].exp_g, vecs[v].exp_o, vecs[v].exp_rej);
         check($sformatf("vec%0d_turn", v), TURN, vecs[v].exp_turn);
      end
      exp_turn = 1'b1;

      // Bounce: short pulses must not produce a move
      for (int b = 0; b < 4; b++) begin
         do_press(4'b0100, 2, 2, ob);
         expect_ev($sformatf("bounce%0d", b), ob, 4'b0000, 4'b0000, 0);
      end
      do_press(4'b0100, 8, 12, ob);
      expect_ev("bounce_move", ob, 4'b0000, 4'b0100, 0);
      exp_turn = 1'b0;
      check("bounce_turn", TURN, exp_turn);

      // Fill column 0 (already holds one disc), then a press into it is rejected
      for (int i = 0; i < ROWS - 1; i++) begin
         do_press(4'b0001, 7, 11, ob);
         expect_ev($sformatf("fill%0d", i), ob, exp_turn ? 4'b0000 : 4'b0001,
                   exp_turn ? 4'b0001 : 4'b0000, 0);
         exp_turn = ~exp_turn;
      end
      check("fill_turn", TURN, exp_turn);
      do_press(4'b0001, 9, 11, ob);
      expect_ev("full_reject", ob, 4'b0000, 4'b0000, 1);
      check("full_turn_kept", TURN, exp_turn);
      do_press(4'b0010, 7, 11, ob);
      expect_ev("after_reject", ob, exp_turn ? 4'b0000 : 4'b0010,
                exp_turn ? 4'b0010 : 4'b0000, 0);
      exp_turn = ~exp_turn;

      // Result arrives during a hold: hold completes, then lock
      BTN = 4'b0100;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1);
         if ((G | O) != '0) found = 1'b1;
      end
      check("lock_hold_seen", found, 1);
      check("lock_not_yet", LOCKED, 0);
      RESULT = 2'b01;
      hc = 1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if ((G | O) != '0) hc++;
         else break;
      end
      check("lock_hold_len", hc, HOLD);
      tick(2);
      check("locked_after_hold", LOCKED, 1);
      BTN = '0;
      tick(4);
      do_press(4'b1000, 10, 10, ob);
      expect_ev("locked_press", ob, 4'b0000, 4'b0000, 0);
      check("locked_stays", LOCKED, 1);
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
      RESULT = 2'b00;
      check("rst2_g", G, 0);
      check("rst2_o", O, 0);
      check("rst2_turn", TURN, 0);
      check("rst2_reject", REJECT, 0);
      check("rst2_locked", LOCKED, 0);

      // Reset in the middle of a hold drops the output on the next edge
      start = 1'b1; tick(1); start = 1'b0; tick(1);
      BTN = 4'b0001;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1);
         if ((G | O) != '0) found = 1'b1;
      end
      check("abort_hold_seen", found, 1);
      RST = 1'b1;
      tick(1);
      check("abort_g", G, 0);
      check("abort_o", O, 0);
      BTN = '0;

      // 24 legal moves fill the board and lock
      do_reset_start();
      exp_turn = 1'b0;
      for (int i = 0; i < ROWS * COLS; i++) begin
         p = 4'b0001 << (i % COLS);
         do_press(p, 7, 11, ob);
         expect_ev($sformatf("full%0d", i), ob, exp_turn ? 4'b0000 : p,
                   exp_turn ? p : 4'b0000, 0);
         exp_turn = ~exp_turn;
         check($sformatf("full%0d_turn", i), TURN, exp_turn);
         check($sformatf("full%0d_locked", i), LOCKED, (i == ROWS * COLS - 1) ? 1 : 0);
      end
      do_press(4'b0001, 8, 8, ob);
      expect_ev("board_full_press", ob, 4'b0000, 4'b0000, 0);

      // Randomized games against a move-level model
      for (int game = 0; game < 2; game++) begin
         do_reset_start();
         for (int c = 0; c < COLS; c++) ht[c] = 0;
         moves = 0; exp_turn = 1'b0; m_locked = 1'b0;
         for (int t = 0; t < 45; t++) begin
            int kind, col;
            kind = $urandom_range(0, 9);
            if (!m_locked && $urandom_range(0, 39) == 0) begin
               RESULT = 2'($urandom_range(1, 3));
               tick(3);
               m_locked = 1'b1;
               check($sformatf("r%0d_%0d_result_lock", game, t), LOCKED, 1);
            end
            if (kind == 0) begin
               do_press(4'b0001 << $urandom_range(0, 3), $urandom_range(1, DEB), 8, ob);
               expect_ev($sformatf("r%0d_%0d_glitch", game, t), ob, 4'b0000, 4'b0000, 0);
            end else if (kind == 1) begin
               do p = 4'($urandom_range(0, 15)); while ($countones(p) < 2);
               do_press(p, $urandom_range(5, 15), 10, ob);
               expect_ev($sformatf("r%0d_%0d_multi", game, t), ob, 4'b0000, 4'b0000, 0);
            end else begin
               col = $urandom_range(0, COLS - 1);
               p = 4'b0001 << col;
               do_press(p, $urandom_range(DEB + 2, 12), $urandom_range(DEB + 6, 12), ob);
               if (m_locked) begin
                  expect_ev($sformatf("r%0d_%0d_lockpress", game, t), ob, 4'b0000, 4'b0000, 0);
               end else if (ht[col] == ROWS) begin
                  expect_ev($sformatf("r%0d_%0d_reject", game, t), ob, 4'b0000, 4'b0000, 1);
               end else begin
                  expect_ev($sformatf("r%0d_%0d_move", game, t), ob, exp_turn ? 4'b0000 : p,
                            exp_turn ? p : 4'b0000, 0);
                  ht[col]++;
                  moves++;
                  exp_turn = ~exp_turn;
                  if (moves == ROWS * COLS) m_locked = 1'b1;
               end
            end
            check($sformatf("r%0d_%0d_turn", game, t), TURN, exp_turn);
            check($sformatf("r%0d_%0d_locked", game, t), LOCKED, m_locked);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
